spi_ram_responder: RTL and testbench

- Synthesizable SPI slave that emulates a 23LC-style serial SRAM, i.e. the device end of the SPI RAM bus our SoC drives as master.
- Used in simulation and FPGA bring-up to stand in for the external SPI RAM, so the CPU's mapped SPI RAM path runs without a physical chip.
- Samples all SPI lines on the system clock, decodes READ (0x03) and WRITE (0x02) with a 24-bit address, and serves an internal byte array with auto-increment.
- A backdoor port lets a bench preload and inspect memory.

---
 rtl/spi_ram_responder_pkg.sv | 25 ++
 rtl/spi_ram_responder_if.sv | 24 ++
 rtl/spi_ram_responder_sync_edge.sv | 36 +++
 rtl/spi_ram_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_spi_ram_responder.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_responder_pkg.sv
// Shared definitions for the SPI RAM responder: opcodes, frame lengths,
// FSM state encoding and the bit positions of the synchronized SPI lines.
package spi_ram_responder_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;

  // Positions of the SPI lines inside the synchronizer vector
  localparam int IDX_SCLK = 0;
  localparam int IDX_CS   = 1;
  localparam int IDX_MOSI = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_IGNORE = 3'd5
  } state_e;

endpackage

// File: rtl/spi_ram_responder_if.sv
// Bus bundle for the SPI RAM responder: the four SPI wires plus the
// backdoor preload/inspect port. The master side is the bench or SoC.
interface spi_ram_responder_if #(
  parameter int ADDR_W = 10
);
  logic              spi_clk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [7:0]        bd_wdata;
  logic [7:0]        bd_rdata;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi, bd_we, bd_addr, bd_wdata,
    input  spi_miso, bd_rdata
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi, bd_we, bd_addr, bd_wdata,
    output spi_miso, bd_rdata
  );
endinterface

// File: rtl/spi_ram_responder_sync_edge.sv
// Multi-bit synchronizer chain for asynchronous SPI lines. Produces the
// synchronized level and single-cycle rise/fall pulses derived from the
// last two synchronized samples.
module spi_sync_edge #(
  parameter int             W       = 3,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] level_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] chain_q [STAGES];
  logic [W-1:0] prev_q;

  // Shift the raw inputs through the synchronizer and keep one extra sample for edges
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[STAGES-1];
    end
  end

  assign level_o = chain_q[STAGES-1];
  assign rise_o  = chain_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI slave emulating a 23LC-style serial SRAM (mode 0, READ/WRITE with a
// 24-bit address and auto-increment). All SPI lines are oversampled on clk.
// A backdoor port preloads/inspects the byte array while the bus is idle.
module spi_ram_responder
  import spi_ram_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  spi_ram_responder_if.slave        bus,
  output logic                      active,
  output logic                      cmd_err
);

  localparam int DEPTH = 1 << ADDR_W;
  // Shift register keeps the bits preceding the current one; wide enough
  // for an opcode or the kept address bits, whichever is longer.
  localparam int SH_W  = (ADDR_W > CMD_BITS) ? ADDR_W : CMD_BITS;

  // ---------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------
  logic [2:0] sync_in;
  logic [2:0] sync_lvl;
  logic [2:0] sync_rise;
  logic [2:0] sync_fall;

  assign sync_in[IDX_SCLK] = bus.spi_clk;
  assign sync_in[IDX_CS]   = bus.spi_cs_n;
  assign sync_in[IDX_MOSI] = bus.spi_mosi;

  // CS_N resets high so a released reset never looks like a new selection
  spi_sync_edge #(
    .W       (3),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (3'b010)
  ) u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .d_i     (sync_in),
    .level_o (sync_lvl),
    .rise_o  (sync_rise),
    .fall_o  (sync_fall)
  );

  logic sclk_rise;
  logic sclk_fall;
  logic cs_high;
  logic cs_fall;
  logic mosi;

  assign sclk_rise = sync_rise[IDX_SCLK];
  assign sclk_fall = sync_fall[IDX_SCLK];
  assign cs_high   = sync_lvl[IDX_CS];
  assign cs_fall   = sync_fall[IDX_CS];
  assign mosi      = sync_lvl[IDX_MOSI];

  logic unused_sync;
  assign unused_sync = ^{sync_lvl[IDX_SCLK], sync_rise[IDX_CS], sync_rise[IDX_MOSI],
                         sync_fall[IDX_MOSI]};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e            state_q,   state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              rd_q,      rd_d;
  logic              miso_q,    miso_d;
  logic              wr_pend_q, wr_pend_d;
  logic              cmd_err_q, cmd_err_d;
  logic              active_q;
  logic [SH_W-2:0]   sh_q,      sh_d;
  logic [7:0]        tx_q,      tx_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        rd_data_q;
  logic [7:0]        bd_rdata_q;
  logic [7:0]        mem [DEPTH];

  logic [7:0]        shifted_byte;
  logic [ADDR_W-1:0] shifted_addr;
  logic              bd_we_ok;

  // The current MOSI bit completes an opcode, data byte or address
  assign shifted_byte = {sh_q[CMD_BITS-2:0], mosi};
  assign shifted_addr = {sh_q[ADDR_W-2:0], mosi};

  // The backdoor may only touch memory while the SPI side is idle
  assign bd_we_ok = bus.bd_we && (state_q == ST_IDLE) && !wr_pend_q;

  // Next-state and datapath decode for the transaction FSM
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    miso_d    = miso_q;
    wr_pend_d = 1'b0;
    cmd_err_d = cmd_err_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    wr_data_d = wr_data_q;

    // A completed write byte lands this cycle; step to the next address
    if (wr_pend_q) addr_d = ADDR_W'(addr_q + 1'b1);

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
      end

      ST_CMD: begin
        if (sclk_rise) begin
          sh_d = {sh_q[SH_W-3:0], mosi};
          if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
            bit_cnt_d = '0;
            if (shifted_byte == OP_READ) begin
              rd_d    = 1'b1;
              state_d = ST_ADDR;
            end else if (shifted_byte == OP_WRITE) begin
              rd_d    = 1'b0;
              state_d = ST_ADDR;
            end else begin
              cmd_err_d = 1'b1;
              state_d   = ST_IGNORE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      ST_ADDR: begin
        if (sclk_rise) begin
          sh_d = {sh_q[SH_W-3:0], mosi};
          if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
            addr_d = shifted_addr;
            if (rd_q) begin
              state_d   = ST_READ;
              // Count "8 bits presented" so the first fall loads a byte
              bit_cnt_d = 5'd8;
            end else begin
              state_d   = ST_WRITE;
              bit_cnt_d = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      ST_READ: begin
        if (sclk_fall) begin
          if (bit_cnt_q == 5'd8) begin
            // rd_data_q already holds mem[addr_q]; move on so the next
            // byte is prefetched long before it is needed
            miso_d    = rd_data_q[7];
            tx_d      = {rd_data_q[6:0], 1'b0};
            addr_d    = ADDR_W'(addr_q + 1'b1);
            bit_cnt_d = 5'd1;
          end else begin
            miso_d    = tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      ST_WRITE: begin
        if (sclk_rise) begin
          sh_d = {sh_q[SH_W-3:0], mosi};
          if (bit_cnt_q == 5'd7) begin
            wr_pend_d = 1'b1;
            wr_data_d = shifted_byte;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      ST_IGNORE: begin
        state_d = ST_IGNORE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Deselect aborts any transaction; a partial byte never reaches memory
    if (cs_high && (state_q != ST_IDLE)) state_d = ST_IDLE;

    // MISO is only ever driven while reading
    if (state_d != ST_READ) miso_d = 1'b0;
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      miso_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      cmd_err_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      miso_q    <= miso_d;
      wr_pend_q <= wr_pend_d;
      cmd_err_q <= cmd_err_d;
      active_q  <= ~cs_high;
    end
  end

  // Shift/data registers carry no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    sh_q      <= sh_d;
    tx_q      <= tx_d;
    wr_data_q <= wr_data_d;
  end

  // Byte array: one write port shared by SPI and backdoor, SPI read prefetch
  always_ff @(posedge clk) begin
    if (wr_pend_q) begin
      mem[addr_q] <= wr_data_q;
    end else if (bd_we_ok) begin
      mem[bus.bd_addr] <= bus.bd_wdata;
    end
    rd_data_q <= mem[addr_q];
  end

  // Registered backdoor read port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bd_rdata_q <= 8'h00;
    end else begin
      bd_rdata_q <= mem[bus.bd_addr];
    end
  end

  assign bus.spi_miso = miso_q;
  assign bus.bd_rdata = bd_rdata_q;
  assign active       = active_q;
  assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: drives SPI mode-0 transactions as a master,
// keeps a plain byte-array model of the RAM and compares read data,
// backdoor contents and status flags against it.
module tb_spi_ram_responder;
  import spi_ram_responder_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int HP     = 8;   // SPI half period in clk cycles

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic active;
  logic cmd_err;

  spi_ram_responder_if #(.ADDR_W(ADDR_W)) bus ();

  spi_ram_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .active  (active),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] model [DEPTH];
  logic [7:0] wbuf [16];
  logic [7:0] rbuf [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int midx(input logic [23:0] a, input int off);
    return (int'(a) + off) % DEPTH;
  endfunction

  task automatic spi_bits(input int n, input logic [31:0] tx, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_mosi = tx[i];
      repeat (HP) @(negedge clk);
      rx[i] = bus.spi_miso;
      bus.spi_clk = 1'b1;
      repeat (HP) @(negedge clk);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HP) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (2 * HP) @(negedge clk);
  endtask

  task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.bd_we    = 1'b1;
    bus.bd_addr  = a;
    bus.bd_wdata = d;
    @(negedge clk);
    bus.bd_we    = 1'b0;
  endtask

  task automatic bd_read(input logic [ADDR_W-1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.bd_addr = a;
    @(negedge clk);
    d = bus.bd_rdata;
  endtask

  task automatic spi_read(input logic [23:0] a, input int n);
    logic [31:0] rx;
    cs_low();
    spi_bits(8, 32'(OP_READ), rx);
    spi_bits(24, 32'(a), rx);
    for (int i = 0; i < n; i++) begin
      spi_bits(8, 32'h0, rx);
      rbuf[i] = rx[7:0];
    end
    cs_high();
  endtask

  task automatic spi_write(input logic [23:0] a, input int n);
    logic [31:0] rx;
    cs_low();
    spi_bits(8, 32'(OP_WRITE), rx);
    spi_bits(24, 32'(a), rx);
    for (int i = 0; i < n; i++) spi_bits(8, 32'(wbuf[i]), rx);
    cs_high();
    for (int i = 0; i < n; i++) model[midx(a, i)] = wbuf[i];
  endtask

  task automatic check_read(input string tag, input logic [23:0] a, input int n);
    spi_read(a, n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(rbuf[i]), 32'(model[midx(a, i)]));
  endtask

  task automatic check_bd(input string tag, input logic [ADDR_W-1:0] a);
    logic [7:0] d;
    bd_read(a, d);
    chk(tag, 32'(d), 32'(model[a]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exceeded, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    logic [7:0]  d;
    logic [23:0] ra;
    logic        miso_seen;
    int          len;
    int          bad;

    bus.spi_clk  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.bd_we    = 1'b0;
    bus.bd_addr  = '0;
    bus.bd_wdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_miso",     32'(bus.spi_miso), 32'h0);
    chk("rst_active",   32'(active),       32'h0);
    chk("rst_cmd_err",  32'(cmd_err),      32'h0);
    chk("rst_bd_rdata", 32'(bus.bd_rdata), 32'h0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Fill memory with known random content
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      model[i] = d;
      bd_write(ADDR_W'(i), d);
    end

    // Basic read of backdoor-preloaded bytes
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h11 * (i + 1));
      model[16 + i] = d;
      bd_write(ADDR_W'(16 + i), d);
    end
    check_read("rd_basic", 24'h000010, 4);
    chk("rd_basic_b0_lit", 32'(rbuf[0]), 32'h11);
    chk("rd_basic_b3_lit", 32'(rbuf[3]), 32'h44);
    chk("cmd_err_after_rd", 32'(cmd_err), 32'h0);

    // Write then inspect via backdoor
    wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
    spi_write(24'h000020, 4);
    for (int i = 0; i < 4; i++) check_bd($sformatf("wr_bd[%0d]", i), ADDR_W'(32 + i));

    // Address wrap for write and read, upper address bits ignored
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    spi_write(24'h0003FF, 2);
    check_bd("wrap_bd_3ff", ADDR_W'(10'h3FF));
    check_bd("wrap_bd_000", ADDR_W'(10'h000));
    check_read("wrap_rd", 24'hFFF3FF, 2);
    chk("wrap_rd_lit0", 32'(rbuf[0]), 32'hA5);
    chk("wrap_rd_lit1", 32'(rbuf[1]), 32'h5A);

    // Partial trailing byte is discarded
    cs_low();
    spi_bits(8, 32'(OP_WRITE), rx);
    spi_bits(24, 32'h000040, rx);
    spi_bits(8, 32'hCC, rx);
    spi_bits(5, 32'(8'h77 >> 3), rx);
    cs_high();
    model[8'h40] = 8'hCC;
    check_bd("partial_40", ADDR_W'(10'h040));
    check_bd("partial_41", ADDR_W'(10'h041));

    // Backdoor write outside IDLE is dropped
    cs_low();
    chk("active_in_xfer", 32'(active), 32'h1);
    bd_write(ADDR_W'(10'h050), ~model[10'h050]);
    cs_high();
    chk("active_after_xfer", 32'(active), 32'h0);
    check_bd("bd_drop_50", ADDR_W'(10'h050));

    // Unknown opcode: sticky error, MISO silent, memory untouched
    cs_low();
    spi_bits(8, 32'h9F, rx);
    miso_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spi_bits(8, $urandom, rx);
      miso_seen = miso_seen | (|rx[7:0]);
    end
    cs_high();
    chk("bad_op_cmd_err", 32'(cmd_err), 32'h1);
    chk("bad_op_miso", 32'(miso_seen), 32'h0);
    ra = 24'($urandom);
    check_read("after_bad_rd", ra, 3);
    chk("cmd_err_sticky", 32'(cmd_err), 32'h1);

    // Randomized write/read traffic against the model
    for (int it = 0; it < 8; it++) begin
      ra  = 24'($urandom);
      len = int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < len; i++) wbuf[i] = 8'($urandom);
        spi_write(ra, len);
      end
      check_read($sformatf("rand%0d", it), ra, len);
    end

    // Reset in the middle of a read
    model[10'h080] = 8'h5A; bd_write(ADDR_W'(10'h080), 8'h5A);
    model[10'h081] = 8'hFF; bd_write(ADDR_W'(10'h081), 8'hFF);
    cs_low();
    spi_bits(8, 32'(OP_READ), rx);
    spi_bits(24, 32'h000080, rx);
    spi_bits(8, 32'h0, rx);
    chk("mid_rst_b0", 32'(rx[7:0]), 32'h5A);
    spi_bits(4, 32'h0, rx);
    chk("mid_rst_nib", 32'(rx[3:0]), 32'hF);
    repeat (HP / 2) @(negedge clk);
    chk("pre_rst_miso", 32'(bus.spi_miso), 32'h1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_miso",    32'(bus.spi_miso), 32'h0);
    chk("mid_rst_active",  32'(active),       32'h0);
    chk("mid_rst_cmd_err", 32'(cmd_err),      32'h0);
    bus.spi_cs_n = 1'b1;
    bus.spi_clk  = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (2 * HP) @(negedge clk);
    check_read("post_rst_rd", 24'h000080, 2);

    // Full memory sweep against the model
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bd_read(ADDR_W'(i), d);
      if (d !== model[i]) bad++;
    end
    chk("mem_sweep_bad", 32'(bad), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
